// File: rtl/toggle_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : toggle_period_meter
// Description : Watches a toggle-flop output and reports rising/falling edge
//               pulses, the clk-cycle distance between consecutive rising
//               edges (saturating at 255), a 16-bit rising-edge counter and
//               a sticky overflow flag for results lost to backpressure.
// Ports       : clk        - clock, all state on rising edge
//               rst        - asynchronous reset, active low
//               data       - monitored signal (synchronous to clk by default)
//               clr        - synchronous clear of measurement state
//               period_rdy - consumer ready for the period result
//               rise/fall  - one-cycle edge pulses
//               period     - measured period, valid while period_vld = 1
//               period_vld - period holds an untransferred result
//               edge_cnt   - rising edges since reset or clr (wraps)
//               ovf        - sticky, a result was dropped under backpressure
// Macro       : TPM_SYNC_STAGE_EN - two extra input flops ahead of s0 for
//               asynchronous sources (adds 2 cycles of edge latency)
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_period_meter (
    input  logic        clk,
    input  logic        rst,
    input  logic        data,
    input  logic        clr,
    input  logic        period_rdy,
    output logic        rise,
    output logic        fall,
    output logic [7:0]  period,
    output logic        period_vld,
    output logic [15:0] edge_cnt,
    output logic        ovf
);

    localparam logic [7:0] C_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_SAT     = 2'd2
    } state_t;

    logic        w_data_s;
    logic        s0_q;
    logic        s1_q;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  period_q;
    logic        period_vld_q;
    logic [15:0] edge_cnt_q;
    logic        ovf_q;
    logic        w_xfer;

`ifdef TPM_SYNC_STAGE_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], data};
        end
    end

    assign w_data_s = sync_q[1];
`else
    assign w_data_s = data;
`endif

    // Edge detector history; clr deliberately leaves it alone so an edge
    // straddling a clear is still seen consistently afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q <= 1'b0;
            s1_q <= 1'b0;
        end else begin
            s0_q <= w_data_s;
            s1_q <= s0_q;
        end
    end

    // Both operands are flops, so the pulses are glitch-free and 0 in reset.
    assign rise = s0_q & ~s1_q;
    assign fall = ~s0_q & s1_q;

    assign w_xfer = period_vld_q & period_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            period_q     <= 8'd0;
            period_vld_q <= 1'b0;
            edge_cnt_q   <= 16'd0;
            ovf_q        <= 1'b0;
        end else if (clr) begin
            // clr wins over a coincident rise: no count, no arm, no result.
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            period_vld_q <= 1'b0;
            edge_cnt_q   <= 16'd0;
            ovf_q        <= 1'b0;
        end else begin
            if (rise) begin
                edge_cnt_q <= edge_cnt_q + 16'd1;
            end
            // Drain on transfer; a load below in the same cycle overrides.
            if (w_xfer) begin
                period_vld_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q <= ST_MEASURE;
                        cnt_q   <= 8'd1;
                    end
                end
                ST_MEASURE, ST_SAT: begin
                    if (rise) begin
                        state_q <= ST_MEASURE;
                        cnt_q   <= 8'd1;
                        // Pending result not taken this cycle: keep it and
                        // flag the loss of the new one.
                        if (period_vld_q && !period_rdy) begin
                            ovf_q <= 1'b1;
                        end else begin
                            period_q     <= cnt_q;
                            period_vld_q <= 1'b1;
                        end
                    end else if (state_q == ST_MEASURE) begin
                        if (cnt_q == C_CNT_MAX) begin
                            state_q <= ST_SAT;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign edge_cnt   = edge_cnt_q;
    assign ovf        = ovf_q;

endmodule
`default_nettype wire
